// File: rtl/ahb_lite_slave_mem.sv
// rtl/ahb_lite_slave_mem.sv - AHB-Lite slave backed by an internal word memory
// OKAY data phases stretch by WAIT_STATES cycles; bad transfers get the two-cycle ERROR response.
module ahb_lite_slave_mem #(
  parameter int BUS_WIDTH   = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 HSEL,
  input  logic [BUS_WIDTH-1:0] HADDR,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [2:0]           HBURST,
  input  logic [3:0]           HPROT,
  input  logic [1:0]           HTRANS,
  input  logic                 HMASTLOCK,
  input  logic                 HREADY,
  input  logic [BUS_WIDTH-1:0] HWDATA,
  output logic [BUS_WIDTH-1:0] HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP
);

  localparam int NB = BUS_WIDTH / 8;
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [1:0] WS_LAST = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          dph_q, dph_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [NB-1:0] strb_q, strb_d;

  logic [BUS_WIDTH-1:0] mem [MEM_DEPTH];

  logic       accept;
  logic       addr_err;
  logic       commit;
  logic [3:0] lane4;
  logic       unused_ok;

  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};
  assign accept    = HSEL & HREADY & HTRANS[1] & ~HRESET;

  always_comb begin
    addr_err = 1'b0;
    if (HSIZE > 3'd2) addr_err = 1'b1;
    if (HSIZE == 3'd1 && HADDR[0]) addr_err = 1'b1;
    if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00) addr_err = 1'b1;
    if ((HADDR >> 2) >= BUS_WIDTH'(MEM_DEPTH)) addr_err = 1'b1;

    // Little-endian lane mask within the 32-bit word
    case (HSIZE)
      3'd0:    lane4 = 4'b0001 << HADDR[1:0];
      3'd1:    lane4 = HADDR[1] ? 4'b1100 : 4'b0011;
      default: lane4 = 4'b1111;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dph_d     = dph_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    strb_d    = strb_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    commit    = 1'b0;

    case (state_q)
      WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt_q == WS_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = ERR2;
      end
      ERR2: begin
        HRESP   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        // IDLE with a pending OKAY phase is its final cycle
        commit = dph_q & wr_q & ~HRESET;
        dph_d  = 1'b0;
      end
    endcase

    if (HREADYOUT && accept) begin
      if (addr_err) begin
        state_d = ERR1;
        dph_d   = 1'b0;
      end else begin
        dph_d  = 1'b1;
        wr_d   = HWRITE;
        idx_d  = HADDR[AW+1:2];
        strb_d = NB'(lane4);
        cnt_d  = '0;
        if (WAIT_STATES > 0) state_d = WAIT;
        else                 state_d = IDLE;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dph_q   <= 1'b0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dph_q   <= dph_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      strb_q  <= strb_d;
    end
  end

  // Memory has no reset so contents survive HRESET
  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int i = 0; i < NB; i++) begin
        if (strb_q[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HRDATA = (dph_q && !wr_q) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// tb/tb_ahb_lite_slave_mem.sv - scoreboard bench for ahb_lite_slave_mem
// Two instances (0 and 2 wait states) share one bus; sel picks which one is addressed and observed.
module tb_ahb_lite_slave_mem;

  typedef struct {
    int          id;
    logic        err;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  exp_t expq[$];
  exp_t cur;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        hreset, hsel, hwrite, hmastlock, hready, sel;
  logic [31:0] haddr, hwdata;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [31:0] rdata0, rdata1, b_rdata;
  logic        ro0, ro1, resp0, resp1, b_ro, b_resp;
  logic        hsel0, hsel1;

  int checks = 0;
  int failures = 0;
  int next_id = 0;
  int lowc = 0;
  bit busy = 0;
  bit mon_en = 0;

  assign hsel0   = hsel & ~sel;
  assign hsel1   = hsel & sel;
  assign b_rdata = sel ? rdata1 : rdata0;
  assign b_ro    = sel ? ro1 : ro0;
  assign b_resp  = sel ? resp1 : resp0;

  ahb_lite_slave_mem #(.BUS_WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
    .HMASTLOCK(hmastlock), .HREADY(hready), .HWDATA(hwdata),
    .HRDATA(rdata0), .HREADYOUT(ro0), .HRESP(resp0)
  );

  ahb_lite_slave_mem #(.BUS_WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(2)) dut1 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel1), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
    .HMASTLOCK(hmastlock), .HREADY(hready), .HWDATA(hwdata),
    .HRDATA(rdata1), .HREADYOUT(ro1), .HRESP(resp1)
  );

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s id=%0d actual=%h required=%h", nm, id, act, req);
    end
  endtask

  // Monitor: pops an expectation when an address phase is accepted, checks every data-phase cycle
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (busy) begin
          chk("dphase_hresp", cur.id, 32'(b_resp), 32'(cur.err));
          chk("dphase_hrdata", cur.id, b_rdata, cur.rdata);
          if (!b_ro) begin
            lowc++;
            if (lowc > 10) begin
              chk("dphase_stuck", cur.id, 32'(lowc), 32'(cur.waits));
              busy = 0;
            end
          end else begin
            chk("wait_cycles", cur.id, 32'(lowc), 32'(cur.waits));
            busy = 0;
          end
        end else begin
          chk("idle_hreadyout", -1, 32'(b_ro), 32'd1);
          chk("idle_hresp", -1, 32'(b_resp), 32'd0);
          chk("idle_hrdata", -1, b_rdata, 32'd0);
        end
        if (hreset) begin
          busy = 0;
        end else if (hsel && hready && htrans[1] && b_ro) begin
          if (expq.size() == 0) begin
            chk("unexpected_accept", -1, 32'd1, 32'd0);
          end else begin
            cur  = expq.pop_front();
            busy = 1;
            lowc = 0;
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, input logic e, input logic [31:0] rd);
    exp_t x;
    int   n;
    x.id    = next_id;
    next_id++;
    x.err   = e;
    x.rdata = (w || e) ? 32'h0 : rd;
    x.waits = e ? 1 : (sel ? 2 : 0);
    expq.push_back(x);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz;
    n = 0;
    @(negedge clk);
    while (!b_ro && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!b_ro) chk("accept_timeout", x.id, 32'd0, 32'd1);
    @(posedge clk);
    #1;
    hwdata = wd; hsel = 1'b0; htrans = 2'b00;
  endtask

  task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d, input logic e);
    issue(1'b1, a, sz, d, e, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] req);
    issue(1'b0, a, 3'd2, 32'h5A5A_5A5A, 1'b0, req);
  endtask

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog id=-1 actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    hreset = 1'b1; hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = 3'd2;
    hburst = 3'd0; hprot = 4'b0011; hmastlock = 1'b0; hready = 1'b1; hwdata = '0; sel = 1'b0;
    cyc(2);
    hreset = 1'b0;
    mon_en = 1'b1;
    cyc(1);

    // Zero-wait instance: word, byte and halfword writes with read-back
    wr(32'h10, 3'd2, 32'hDEAD_BEEF, 1'b0);
    rd(32'h10, 32'hDEAD_BEEF);
    wr(32'h10, 3'd2, 32'h1122_3344, 1'b0);
    wr(32'h13, 3'd0, 32'hAA00_0000, 1'b0);
    rd(32'h10, 32'hAA22_3344);
    wr(32'h14, 3'd2, 32'h0102_0304, 1'b0);
    wr(32'h16, 3'd1, 32'hBEEF_0000, 1'b0);
    rd(32'h14, 32'hBEEF_0304);
    wr(32'h00, 3'd2, 32'h0BAD_F00D, 1'b0);
    wr(32'hFC, 3'd2, 32'h3F3F_3F3F, 1'b0);

    // Error transfers: misaligned word, out of range, bad size, odd halfword, bad read
    wr(32'h02, 3'd2, 32'h1111_1111, 1'b1);
    wr(32'h100, 3'd2, 32'h2222_2222, 1'b1);
    wr(32'h00, 3'd3, 32'h3333_3333, 1'b1);
    wr(32'hFD, 3'd1, 32'h4444_4444, 1'b1);
    issue(1'b0, 32'h102, 3'd2, 32'h0, 1'b1, 32'h0);
    rd(32'h00, 32'h0BAD_F00D);
    rd(32'hFC, 32'h3F3F_3F3F);
    cyc(1);

    // IDLE, BUSY, deselected and HREADY-low cycles must not touch memory
    hsel = 1'b1; htrans = 2'b00; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2; hwdata = 32'hFFFF_FFFF;
    cyc(2);
    htrans = 2'b01;
    cyc(1);
    hsel = 1'b0; htrans = 2'b10;
    cyc(2);
    hsel = 1'b1; hready = 1'b0;
    cyc(1);
    hready = 1'b1; hsel = 1'b0; htrans = 2'b00;
    rd(32'h10, 32'hAA22_3344);
    cyc(1);

    // Two-wait-state instance
    sel = 1'b1;
    cyc(1);
    wr(32'h20, 3'd2, 32'h1234_5678, 1'b0);
    rd(32'h20, 32'h1234_5678);
    wr(32'h22, 3'd2, 32'h9999_9999, 1'b1);
    rd(32'h20, 32'h1234_5678);
    cyc(1);

    // Reset in the second wait cycle of a write; a read presented during reset is ignored
    wr(32'h20, 3'd2, 32'hFFFF_FFFF, 1'b0);
    cyc(1);
    hreset = 1'b1; hsel = 1'b1; htrans = 2'b10; haddr = 32'h24; hwrite = 1'b0;
    cyc(1);
    hreset = 1'b0; hsel = 1'b0; htrans = 2'b00;
    cyc(1);
    rd(32'h20, 32'h1234_5678);
    cyc(3);

    // Zero-wait memory survives the reset
    sel = 1'b0;
    cyc(1);
    rd(32'h10, 32'hAA22_3344);
    cyc(3);

    chk("queue_drained", -1, 32'(expq.size()), 32'd0);
    chk("monitor_idle", -1, 32'(busy), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_lite_slave_mem.md
AHB_LITE_SLAVE_MEM -- requirements
Module: ahb_lite_slave_mem

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, meaning the HADDR/HWDATA/HRDATA width.
REQ-002 SHALL have parameter MEM_DEPTH, default 64, meaning the number of BUS_WIDTH-bit words in internal memory.
REQ-003 SHALL have parameter WAIT_STATES, default 0 (legal 0-3), meaning HREADYOUT-low cycles inserted per OKAY data phase.
REQ-004 SHALL have ports: HCLK in 1 clock; one clock, all logic on rising edge.
REQ-005 SHALL have port HRESET in 1; reset is synchronous and active-high.
REQ-006 SHALL have ports HSEL in 1 slave select; HADDR in BUS_WIDTH address; HWRITE in 1 (1=write); HSIZE in 3 transfer size; HBURST in 3 (accepted, ignored); HPROT in 4 (accepted, ignored); HTRANS in 2 (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11); HMASTLOCK in 1 (ignored).
REQ-007 SHALL have ports HREADY in 1 bus-wide ready; HWDATA in BUS_WIDTH write data; HRDATA out BUS_WIDTH read data; HREADYOUT out 1 slave ready; HRESP out 1 (0=OKAY, 1=ERROR).

Function
REQ-010 Address phase accepted SHALL mean HSEL=1, HREADY=1 and HTRANS[1]=1 at a rising edge; HADDR, HWRITE, HSIZE captured at that edge.
REQ-011 IDLE/BUSY, HSEL=0 or HREADY=0 SHALL capture nothing; next cycle is zero-wait OKAY (HREADYOUT=1, HRESP=0).
REQ-012 Error check at acceptance: HSIZE>2, HSIZE=1 with HADDR[0]=1, HSIZE=2 with HADDR[1:0]!=0, or word index HADDR>>2 >= MEM_DEPTH SHALL flag the transfer as error.
REQ-013 FSM states SHALL be IDLE, WAIT, ERR1, ERR2.
REQ-014 IDLE: HREADYOUT=1, HRESP=0; accepted OKAY transfer -> WAIT if WAIT_STATES>0, else stays IDLE with a 1-cycle data phase; accepted error transfer -> ERR1.
REQ-015 WAIT: HREADYOUT=0, HRESP=0 for exactly WAIT_STATES cycles (counter), then one final data-phase cycle with HREADYOUT=1 (IDLE-output behaviour).
REQ-016 ERR1: HREADYOUT=0, HRESP=1, always -> ERR2; ERR2: HREADYOUT=1, HRESP=1, -> IDLE (or new acceptance per REQ-014).
REQ-017 A new address phase SHALL only be accepted in a cycle where HREADYOUT=1 (final data-phase cycle or idle), enabling back-to-back pipelined transfers.
REQ-018 Write SHALL commit at the edge ending the final OKAY data-phase cycle, using HWDATA sampled then; only byte lanes selected by HSIZE and HADDR[1:0] (little-endian) updated.
REQ-019 Read SHALL drive HRDATA = full word at captured index during every data-phase cycle of an OKAY read; HRDATA=0 otherwise, including error and write phases.
REQ-020 Read immediately following a write to the same word SHALL return the newly written data (write commits before read data phase).
REQ-021 Error transfers SHALL never modify memory.
REQ-022 Memory contents SHALL not be cleared by reset.

Reset
REQ-030 HRESET=1 at an edge SHALL force state IDLE, wait counter 0, captured transfer discarded, HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-031 Reset during WAIT, ERR1 or ERR2 SHALL abandon the transfer with no memory write.
REQ-032 A transfer presented during a reset cycle SHALL not be accepted.

Verification
REQ-040 WAIT_STATES=0: NONSEQ write 0x0000_0010 word 0xDEAD_BEEF, then NONSEQ read same address -> read data phase HRDATA=0xDEAD_BEEF, HREADYOUT=1, HRESP=0 every cycle.
REQ-041 Byte write HSIZE=0 to 0x0000_0013 data 0xAA00_0000 over prior 0x1122_3344 -> read of 0x10 returns 0xAA22_3344.
REQ-042 WAIT_STATES=2: single read -> HREADYOUT low exactly 2 cycles then high with valid data; next NONSEQ accepted only in that high cycle.
REQ-043 Word write to 0x0000_0002 (misaligned) and to 0x0000_0100 (index 64, out of range) -> HREADYOUT 0/1 with HRESP 1/1 over two cycles; later read of affected words shows unchanged contents.
REQ-044 HRESET asserted during 2nd wait cycle of a write -> next cycle HREADYOUT=1, HRESP=0, HRDATA=0; target word unchanged.
REQ-045 HTRANS=IDLE and HSEL=0 cycles interleaved with transfers -> no memory change, HREADYOUT=1, HRESP=0.
